// File: rtl/median_pkg.sv
// Shared constants and helpers for the median filter datapath: kernel geometry,
// window slot indexing and counter width sizing.
package median_pkg;

    localparam int KERNEL      = 3;
    localparam int WIN_PIXELS  = KERNEL * KERNEL;
    localparam int SLOT_CENTER = 4;

    // Slot of the pixel at row offset i, column offset j (0 = newest).
    function automatic int slot(input int i, input int j);
        return KERNEL * i + j;
    endfunction

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One line of pixel storage, addressed by column; asynchronous read returns the
// old contents in the same cycle the new pixel is written.
module line_buffer
    import median_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [cnt_w(IMG_WIDTH)-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic [DATA_WIDTH-1:0]        rdata
);

    logic [DATA_WIDTH-1:0] mem_q [IMG_WIDTH];

    assign rdata = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift
// array, emitting one packed window per interior raster pixel.
module window_3x3_gen
    import median_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic                             in_sof,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic                             out_valid,
    output logic                             out_eof,
    output logic [WIN_PIXELS*DATA_WIDTH-1:0] window
);

    localparam int CW = cnt_w(IMG_WIDTH);
    localparam int RW = cnt_w(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(KERNEL - 1);

    logic [CW-1:0] col_q, col_d, pos_col;
    logic [RW-1:0] row_q, row_d, pos_row;
    logic [DATA_WIDTH-1:0] arr_q [KERNEL][KERNEL];
    logic [DATA_WIDTH-1:0] arr_d [KERNEL][KERNEL];
    logic [WIN_PIXELS*DATA_WIDTH-1:0] win_q, win_d;
    logic valid_q, valid_d, eof_q, eof_d;
    logic [DATA_WIDTH-1:0] lb1_rd, lb2_rd;
    logic lb_we, emit;

    // A start-of-frame beat is placed at (0,0) regardless of counter state.
    assign pos_col = in_sof ? '0 : col_q;
    assign pos_row = in_sof ? '0 : row_q;
    assign lb_we   = in_valid & rst_n;
    assign emit    = in_valid && (pos_row >= ROW_MIN) && (pos_col >= COL_MIN);

    line_buffer #(.DATA_WIDTH(DATA_WIDTH), .IMG_WIDTH(IMG_WIDTH)) u_lb1 (
        .clk(clk), .we(lb_we), .addr(pos_col), .wdata(in_data), .rdata(lb1_rd)
    );

    line_buffer #(.DATA_WIDTH(DATA_WIDTH), .IMG_WIDTH(IMG_WIDTH)) u_lb2 (
        .clk(clk), .we(lb_we), .addr(pos_col), .wdata(lb1_rd), .rdata(lb2_rd)
    );

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        arr_d   = arr_q;
        win_d   = win_q;
        valid_d = 1'b0;
        eof_d   = 1'b0;
        if (in_valid) begin
            if (pos_col == COL_LAST) begin
                col_d = '0;
                row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
            end else begin
                col_d = pos_col + 1'b1;
                row_d = pos_row;
            end
            for (int i = 0; i < KERNEL; i++) begin
                arr_d[i][2] = arr_q[i][1];
                arr_d[i][1] = arr_q[i][0];
            end
            arr_d[0][0] = in_data;
            arr_d[1][0] = lb1_rd;
            arr_d[2][0] = lb2_rd;
            if (emit) begin
                valid_d = 1'b1;
                eof_d   = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
                for (int i = 0; i < KERNEL; i++) begin
                    for (int j = 0; j < KERNEL; j++) begin
                        win_d[slot(i, j)*DATA_WIDTH +: DATA_WIDTH] = arr_d[i][j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
            for (int i = 0; i < KERNEL; i++) begin
                for (int j = 0; j < KERNEL; j++) begin
                    arr_q[i][j] <= '0;
                end
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            eof_q   <= eof_d;
            arr_q   <= arr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_eof   = eof_q;
    assign window    = win_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 4x4 image with pixel value 4*row+col.
module tb_window_3x3_gen;

    localparam int DW = 8;
    localparam int WW = 9 * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_sof;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_eof;
    logic [WW-1:0] window;

    int checks = 0;
    int errors = 0;

    logic [WW-1:0] wq[$];
    logic          eq[$];
    logic [DW-1:0] dq[$];

    window_3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .out_valid(out_valid), .out_eof(out_eof), .window(window)
    );

    always #5 clk = ~clk;

    // Window around (r,c): slot 3*i+j holds the pixel at (r-i, c-j).
    function automatic logic [WW-1:0] exp_win(input int r, input int c, input int base);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(3*i+j)*DW +: DW] = DW'(base + 4*(r-i) + (c-j));
        return w;
    endfunction

    task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        #1;
        if (out_valid) begin
            wq.push_back(window);
            eq.push_back(out_eof);
            dq.push_back(in_data);
        end
    endtask

    task automatic clear_q();
        wq.delete();
        eq.delete();
        dq.delete();
    endtask

    task automatic send_frame(input int base, input logic sof_first);
        for (int p = 0; p < 16; p++)
            step(1'b1, sof_first && (p == 0), DW'(base + p));
        step(1'b0, 1'b0, '0);
    endtask

    task automatic check_frame_windows(input string name, input int first, input int base);
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (wq.size() <= first + n) begin
                errors++;
                $display("FAIL %s win%0d missing: have %0d windows", name, n, wq.size());
            end else begin
                if (wq[first+n] !== exp_win(2 + n/2, 2 + n%2, base)) begin
                    errors++;
                    $display("FAIL %s win%0d got %h want %h", name, n, wq[first+n],
                             exp_win(2 + n/2, 2 + n%2, base));
                end
                checks++;
                if (eq[first+n] !== (n == 3)) begin
                    errors++;
                    $display("FAIL %s eof%0d got %b want %b", name, n, eq[first+n], (n == 3));
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++;
        if (out_eof !== 1'b0) begin errors++; $display("FAIL reset_eof got %b want 0", out_eof); end
        checks++;
        if (window !== '0) begin errors++; $display("FAIL reset_window got %h want 0", window); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_frame();
        clear_q();
        send_frame(0, 1'b1);
        checks++;
        if (wq.size() != 4) begin errors++; $display("FAIL full_count got %0d want 4", wq.size()); end
        if (wq.size() > 0) begin
            checks++;
            if (wq[0] !== 72'h00_01_02_04_05_06_08_09_0A) begin
                errors++; $display("FAIL full_first got %h want 000102040506080 90A", wq[0]);
            end
            checks++;
            if (dq[0] !== 8'd10) begin errors++; $display("FAIL full_first_beat got %0d want 10", dq[0]); end
        end
        if (wq.size() == 4) begin
            checks++;
            if (wq[3][7:0] !== 8'd15 || wq[3][71:64] !== 8'd5 || eq[3] !== 1'b1) begin
                errors++;
                $display("FAIL full_last got s0=%0d s8=%0d eof=%b want 15 5 1",
                         wq[3][7:0], wq[3][71:64], eq[3]);
            end
        end
        check_frame_windows("full", 0, 0);
    endtask

    task automatic test_gapped();
        int gap_bad = 0;
        clear_q();
        for (int p = 0; p < 16; p++) begin
            step(1'b1, p == 0, DW'(p));
            step(1'b0, 1'b0, 8'hEE);
            if (out_valid !== 1'b0) gap_bad++;
            if (wq.size() > 0 && window !== wq[wq.size()-1]) gap_bad++;
        end
        checks++;
        if (gap_bad != 0) begin errors++; $display("FAIL gapped_idle got %0d bad gap cycles want 0", gap_bad); end
        checks++;
        if (wq.size() != 4) begin errors++; $display("FAIL gapped_count got %0d want 4", wq.size()); end
        check_frame_windows("gapped", 0, 0);
    endtask

    task automatic test_two_frames();
        int out_of_range = 0;
        clear_q();
        for (int p = 0; p < 16; p++) step(1'b1, p == 0, DW'(p));
        for (int p = 0; p < 16; p++) step(1'b1, p == 0, DW'(100 + p));
        step(1'b0, 1'b0, '0);
        checks++;
        if (wq.size() != 8) begin errors++; $display("FAIL two_count got %0d want 8", wq.size()); end
        check_frame_windows("two_a", 0, 0);
        check_frame_windows("two_b", 4, 100);
        for (int n = 4; n < wq.size(); n++)
            for (int k = 0; k < 9; k++)
                if (wq[n][k*DW +: DW] < 8'd100 || wq[n][k*DW +: DW] > 8'd115) out_of_range++;
        checks++;
        if (out_of_range != 0) begin
            errors++; $display("FAIL two_range got %0d foreign slots want 0", out_of_range);
        end
    endtask

    task automatic test_sof_resync();
        clear_q();
        for (int p = 0; p < 7; p++) step(1'b1, p == 0, DW'(200 + p));
        checks++;
        if (wq.size() != 0) begin errors++; $display("FAIL resync_aborted got %0d windows want 0", wq.size()); end
        send_frame(0, 1'b1);
        checks++;
        if (wq.size() != 4) begin errors++; $display("FAIL resync_count got %0d want 4", wq.size()); end
        if (wq.size() > 0) begin
            checks++;
            if (wq[0] !== 72'h00_01_02_04_05_06_08_09_0A || dq[0] !== 8'd10) begin
                errors++; $display("FAIL resync_first got %h beat %0d want 00010204050608090a beat 10", wq[0], dq[0]);
            end
        end
        check_frame_windows("resync", 0, 0);
    endtask

    task automatic test_reset_mid();
        clear_q();
        for (int p = 0; p < 10; p++) step(1'b1, p == 0, DW'(50 + p));
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; in_sof = 1'b0; in_data = 8'h77;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
        checks++;
        if (window !== '0) begin errors++; $display("FAIL rstmid_window got %h want 0", window); end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        clear_q();
        send_frame(0, 1'b0);
        checks++;
        if (wq.size() != 4) begin errors++; $display("FAIL rstmid_count got %0d want 4", wq.size()); end
        check_frame_windows("rstmid", 0, 0);
    endtask

    task automatic test_saturation();
        int bad = 0;
        clear_q();
        for (int p = 0; p < 16; p++) step(1'b1, p == 0, 8'hFF);
        step(1'b0, 1'b0, '0);
        checks++;
        if (wq.size() != 4) begin errors++; $display("FAIL sat_count got %0d want 4", wq.size()); end
        for (int n = 0; n < wq.size(); n++)
            if (wq[n] !== {9{8'hFF}}) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL sat_slots got %0d bad windows want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gapped();
        test_two_frames();
        test_sof_resync();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
